// File: rtl/layer_result_reader.sv
// Result reader for the output layer: captures three float32 outputs on completion,
// resolves argmax over two compare cycles and offers the winner over valid/ready.
module layer_result_reader #(
  parameter int IDX_BASE        = 0,
  parameter bit HOLD_ON_OVERRUN = 1'b1
) (
  input  logic        clk_x70,
  input  logic        reset_x70,
  input  logic        done_x70,
  input  logic [31:0] y1_x70,
  input  logic [31:0] y2_x70,
  input  logic [31:0] y3_x70,
  output logic        class_valid_x70,
  input  logic        class_ready_x70,
  output logic [1:0]  class_idx_x70,
  output logic [31:0] class_max_x70,
  output logic        all_zero_x70,
  output logic        overrun_x70,
  output logic [7:0]  result_cnt_x70
);

  typedef enum logic [1:0] {IDLE, CMP1, CMP2, OUT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_done_q;
  logic [31:0] r_cap0, r_cap1, r_cap2;
  logic [31:0] r_best;
  logic [1:0]  r_best_idx;
  logic [1:0]  r_idx;
  logic [31:0] r_max;
  logic        r_all_zero;
  logic        r_overrun;
  logic [7:0]  r_cnt;

  logic        w_event;
  logic        w_capture;
  logic        w_handshake;
  logic        w_set_overrun;
  logic        w_take1;
  logic        w_take2;

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Strict a > b; a NaN candidate never wins, any non-NaN beats a NaN incumbent.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    logic r;
    r = 1'b0;
    if (fp_is_nan(a))                               r = 1'b0;
    else if (fp_is_nan(b))                          r = 1'b1;
    else if (a[30:0] == 31'd0 && b[30:0] == 31'd0)  r = 1'b0;
    else if (a[31] != b[31])                        r = !a[31];
    else if (!a[31])                                r = (a[30:0] > b[30:0]);
    else                                            r = (a[30:0] < b[30:0]);
    return r;
  endfunction

  assign w_event = done_x70 & !r_done_q;
  assign w_take1 = fp_gt(r_cap1, r_cap0);
  assign w_take2 = fp_gt(r_cap2, r_best);

  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_handshake   = 1'b0;
    w_set_overrun = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_event) begin
          w_capture   = 1'b1;
          w_state_nxt = CMP1;
        end
      end
      CMP1: begin
        w_set_overrun = w_event;
        w_state_nxt   = CMP2;
      end
      CMP2: begin
        w_set_overrun = w_event;
        w_state_nxt   = OUT;
      end
      OUT: begin
        if (class_ready_x70) begin
          // A completion coinciding with the handshake is a clean follow-on, not an overrun.
          w_handshake = 1'b1;
          w_capture   = w_event;
          w_state_nxt = w_event ? CMP1 : IDLE;
        end else if (w_event) begin
          w_set_overrun = 1'b1;
          if (!HOLD_ON_OVERRUN) begin
            w_capture   = 1'b1;
            w_state_nxt = CMP1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_x70) begin
    if (reset_x70) begin
      r_state    <= IDLE;
      r_done_q   <= 1'b0;
      r_cap0     <= '0;
      r_cap1     <= '0;
      r_cap2     <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_idx      <= '0;
      r_max      <= '0;
      r_all_zero <= 1'b0;
      r_overrun  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_done_q <= done_x70;
      if (w_capture) begin
        r_cap0 <= y1_x70;
        r_cap1 <= y2_x70;
        r_cap2 <= y3_x70;
      end
      if (r_state == CMP1) begin
        r_best     <= w_take1 ? r_cap1 : r_cap0;
        r_best_idx <= w_take1 ? 2'd1 : 2'd0;
      end
      if (r_state == CMP2) begin
        r_max      <= w_take2 ? r_cap2 : r_best;
        r_idx      <= (w_take2 ? 2'd2 : r_best_idx) + 2'(IDX_BASE);
        r_all_zero <= (r_cap0[30:0] == 31'd0) && (r_cap1[30:0] == 31'd0) &&
                      (r_cap2[30:0] == 31'd0);
      end
      if (w_set_overrun) r_overrun <= 1'b1;
      if (w_handshake)   r_cnt     <= r_cnt + 8'd1;
    end
  end

  assign class_valid_x70 = (r_state == OUT);
  assign class_idx_x70   = r_idx;
  assign class_max_x70   = r_max;
  assign all_zero_x70    = r_all_zero;
  assign overrun_x70     = r_overrun;
  assign result_cnt_x70  = r_cnt;

endmodule

// File: tb/tb_layer_result_reader.sv
// Directed bench for layer_result_reader: one hold-mode and one overwrite-mode instance.
module tb_layer_result_reader;

  logic        clk, reset, done, ready;
  logic [31:0] y1, y2, y3;
  logic        h_valid, h_zero, h_ovr, o_valid, o_zero, o_ovr;
  logic [1:0]  h_idx, o_idx;
  logic [31:0] h_max, o_max;
  logic [7:0]  h_cnt, o_cnt;
  int          checks = 0;
  int          errors = 0;

  layer_result_reader #(.IDX_BASE(0), .HOLD_ON_OVERRUN(1'b1)) dut_h (
    .clk_x70(clk), .reset_x70(reset), .done_x70(done),
    .y1_x70(y1), .y2_x70(y2), .y3_x70(y3),
    .class_valid_x70(h_valid), .class_ready_x70(ready), .class_idx_x70(h_idx),
    .class_max_x70(h_max), .all_zero_x70(h_zero), .overrun_x70(h_ovr),
    .result_cnt_x70(h_cnt)
  );

  layer_result_reader #(.IDX_BASE(0), .HOLD_ON_OVERRUN(1'b0)) dut_o (
    .clk_x70(clk), .reset_x70(reset), .done_x70(done),
    .y1_x70(y1), .y2_x70(y2), .y3_x70(y3),
    .class_valid_x70(o_valid), .class_ready_x70(ready), .class_idx_x70(o_idx),
    .class_max_x70(o_max), .all_zero_x70(o_zero), .overrun_x70(o_ovr),
    .result_cnt_x70(o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1; done = 1'b0; ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; done = 1'b0; ready = 1'b0;
    y1 = 32'h0; y2 = 32'h0; y3 = 32'h0;
    tick(2);
    checks++; if ({h_valid, h_idx, h_max, h_zero, h_ovr, h_cnt} !== 45'd0) begin errors++;
      $display("FAIL reset_h got %0b %0d %h %0b %0b %0d exp zeros", h_valid, h_idx, h_max, h_zero, h_ovr, h_cnt); end
    checks++; if ({o_valid, o_idx, o_max, o_zero, o_ovr, o_cnt} !== 45'd0) begin errors++;
      $display("FAIL reset_o got %0b %0d %h %0b %0b %0d exp zeros", o_valid, o_idx, o_max, o_zero, o_ovr, o_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    y1 = 32'h3F800000; y2 = 32'h40600000; y3 = 32'h3F000000;
    ready = 1'b1; done = 1'b1;
    tick(2);
    checks++; if (h_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b exp 0", h_valid); end
    tick();
    checks++; if (h_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", h_valid); end
    checks++; if (h_idx !== 2'd1) begin errors++; $display("FAIL basic_idx got %0d exp 1", h_idx); end
    checks++; if (h_max !== 32'h40600000) begin errors++; $display("FAIL basic_max got %h exp 40600000", h_max); end
    checks++; if (h_zero !== 1'b0) begin errors++; $display("FAIL basic_zero got %0b exp 0", h_zero); end
    checks++; if (h_cnt !== 8'd0) begin errors++; $display("FAIL basic_cnt_pre got %0d exp 0", h_cnt); end
    tick();
    checks++; if (h_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt got %0d exp 1", h_cnt); end
    checks++; if (h_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %0b exp 0", h_valid); end
    done = 1'b0;
    tick();
  endtask

  task automatic test_ties_zeros();
    y1 = 32'h0; y2 = 32'h0; y3 = 32'h0; done = 1'b1;
    tick(3);
    checks++; if (h_idx !== 2'd0 || h_zero !== 1'b1 || h_valid !== 1'b1) begin errors++;
      $display("FAIL zeros1 got idx %0d zero %0b valid %0b exp 0 1 1", h_idx, h_zero, h_valid); end
    tick(); done = 1'b0; tick();
    y1 = 32'h80000000; done = 1'b1;
    tick(3);
    checks++; if (h_idx !== 2'd0 || h_zero !== 1'b1 || h_valid !== 1'b1) begin errors++;
      $display("FAIL zeros2 got idx %0d zero %0b valid %0b exp 0 1 1", h_idx, h_zero, h_valid); end
    checks++; if (h_max !== 32'h80000000) begin errors++; $display("FAIL zeros2_max got %h exp 80000000", h_max); end
    tick(); done = 1'b0; tick();
  endtask

  task automatic test_nan_sign();
    y1 = 32'h7FC00000; y2 = 32'hBF800000; y3 = 32'hBF000000; done = 1'b1;
    tick(3);
    checks++; if (h_idx !== 2'd2) begin errors++; $display("FAIL nan_idx got %0d exp 2", h_idx); end
    checks++; if (h_max !== 32'hBF000000) begin errors++; $display("FAIL nan_max got %h exp BF000000", h_max); end
    checks++; if (h_zero !== 1'b0) begin errors++; $display("FAIL nan_zero got %0b exp 0", h_zero); end
    tick(); done = 1'b0; tick();
    checks++; if (h_cnt !== 8'd4) begin errors++; $display("FAIL nan_cnt got %0d exp 4", h_cnt); end
  endtask

  task automatic test_hold();
    pulse_reset();
    y1 = 32'h3F800000; y2 = 32'h40600000; y3 = 32'h3F000000; done = 1'b1;
    tick(3);
    done = 1'b0; tick();
    y3 = 32'h41000000; done = 1'b1;
    tick();
    checks++; if (h_ovr !== 1'b1) begin errors++; $display("FAIL hold_ovr got %0b exp 1", h_ovr); end
    tick(2);
    checks++; if (h_valid !== 1'b1 || h_idx !== 2'd1 || h_max !== 32'h40600000) begin errors++;
      $display("FAIL hold_pending got valid %0b idx %0d max %h exp 1 1 40600000", h_valid, h_idx, h_max); end
    ready = 1'b1;
    tick();
    checks++; if (h_cnt !== 8'd1 || h_valid !== 1'b0) begin errors++;
      $display("FAIL hold_hs got cnt %0d valid %0b exp 1 0", h_cnt, h_valid); end
    tick(4);
    checks++; if (h_cnt !== 8'd1 || h_valid !== 1'b0) begin errors++;
      $display("FAIL hold_no_second got cnt %0d valid %0b exp 1 0", h_cnt, h_valid); end
  endtask

  task automatic test_reset_mid();
    done = 1'b0; tick();
    y1 = 32'h3F800000; y2 = 32'h40600000; y3 = 32'h3F000000; done = 1'b1;
    tick(2);
    reset = 1'b1;
    tick();
    checks++; if (h_valid !== 1'b0 || h_cnt !== 8'd0 || h_ovr !== 1'b0) begin errors++;
      $display("FAIL rmid_reset got valid %0b cnt %0d ovr %0b exp 0 0 0", h_valid, h_cnt, h_ovr); end
    tick();
    checks++; if (h_valid !== 1'b0) begin errors++; $display("FAIL rmid_reset2 got %0b exp 0", h_valid); end
    reset = 1'b0;
    tick(2);
    checks++; if (h_valid !== 1'b0) begin errors++; $display("FAIL rmid_early got %0b exp 0", h_valid); end
    tick();
    checks++; if (h_valid !== 1'b1 || h_idx !== 2'd1 || h_cnt !== 8'd0 || h_ovr !== 1'b0) begin errors++;
      $display("FAIL rmid_result got valid %0b idx %0d cnt %0d ovr %0b exp 1 1 0 0", h_valid, h_idx, h_cnt, h_ovr); end
    tick(4);
    checks++; if (h_valid !== 1'b0 || h_cnt !== 8'd1) begin errors++;
      $display("FAIL rmid_once got valid %0b cnt %0d exp 0 1", h_valid, h_cnt); end
  endtask

  task automatic test_overwrite();
    pulse_reset();
    y1 = 32'h3F800000; y2 = 32'h40600000; y3 = 32'h3F000000; done = 1'b1;
    tick(3);
    done = 1'b0; tick();
    y3 = 32'h41000000; done = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b0 || o_ovr !== 1'b1) begin errors++;
      $display("FAIL ovw_drop got valid %0b ovr %0b exp 0 1", o_valid, o_ovr); end
    tick(2);
    checks++; if (o_valid !== 1'b1 || o_idx !== 2'd2 || o_max !== 32'h41000000 || o_ovr !== 1'b1) begin errors++;
      $display("FAIL ovw_result got valid %0b idx %0d max %h ovr %0b exp 1 2 41000000 1", o_valid, o_idx, o_max, o_ovr); end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    y1 = 32'h3F800000; y2 = 32'h40600000; y3 = 32'h3F000000; done = 1'b1;
    tick(3);
    done = 1'b0; tick();
    y3 = 32'h41000000; done = 1'b1; ready = 1'b1;
    tick();
    checks++; if (h_cnt !== 8'd1 || h_valid !== 1'b0 || h_ovr !== 1'b0) begin errors++;
      $display("FAIL b2b_hs got cnt %0d valid %0b ovr %0b exp 1 0 0", h_cnt, h_valid, h_ovr); end
    checks++; if (o_cnt !== 8'd1 || o_ovr !== 1'b0) begin errors++;
      $display("FAIL b2b_hs_o got cnt %0d ovr %0b exp 1 0", o_cnt, o_ovr); end
    tick(2);
    checks++; if (h_valid !== 1'b1 || h_idx !== 2'd2 || h_max !== 32'h41000000) begin errors++;
      $display("FAIL b2b_second got valid %0b idx %0d max %h exp 1 2 41000000", h_valid, h_idx, h_max); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties_zeros();
    test_nan_sign();
    test_hold();
    test_reset_mid();
    test_overwrite();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
